// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: command field positions, length codes and LSU states.
package mem_pkg;

  localparam int unsigned E_EN     = 4;
  localparam int unsigned E_LEN_HI = 3;
  localparam int unsigned E_LEN_LO = 2;
  localparam int unsigned E_WR     = 1;
  localparam int unsigned E_UNS    = 0;

  localparam logic [1:0] LEN_B = 2'd0;
  localparam logic [1:0] LEN_H = 2'd1;
  localparam logic [1:0] LEN_W = 2'd3;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } mem_state_e;

endpackage

// File: rtl/mem_byte_ext.sv
// Extends an assembled little-endian load of 1-4 bytes to 32 bits (zero or sign).
module mem_byte_ext
  import mem_pkg::*;
(
  input  logic [31:0] bytes_i,
  input  logic [1:0]  len_i,
  input  logic        uns_i,
  output logic [31:0] val_o
);

  always_comb begin
    val_o = bytes_i;
    case (len_i)
      LEN_B:   val_o = {{24{~uns_i & bytes_i[7]}},  bytes_i[7:0]};
      LEN_H:   val_o = {{16{~uns_i & bytes_i[15]}}, bytes_i[15:0]};
      LEN_W:   val_o = bytes_i;
      default: val_o = {{8{~uns_i & bytes_i[23]}},  bytes_i[23:0]};
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM pipeline stage with a byte-serial load/store unit on an 8-bit req/ack port.
// Optional macro MEM_FWD_EN adds fwd_we/fwd_wa/fwd_res next-value forwarding outputs.
module mem_lsu
  import mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned XLEN   = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      ex_mem_e,
  input  logic [XLEN-1:0] ex_mem_n,
  input  logic [XLEN-1:0] res,
  input  logic [4:0]      wa,
  input  logic            we,
  output logic            stall_o,
  output logic [4:0]      wa_o,
  output logic            we_o,
  output logic [XLEN-1:0] res_o,
  output logic            mem_req,
  input  logic            mem_ack,
  output logic            mem_wr,
  output logic [XLEN-1:0] mem_a,
  output logic [7:0]      mem_dout,
  input  logic [7:0]      mem_din
`ifdef MEM_FWD_EN
  ,
  output logic            fwd_we,
  output logic [4:0]      fwd_wa,
  output logic [XLEN-1:0] fwd_res
`endif
);

  localparam int unsigned CntW = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

  mem_state_e      state_q, state_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [1:0]      len_q, len_d;
  logic            wr_q, wr_d;
  logic            uns_q, uns_d;
  logic [4:0]      wa_q, wa_d;
  logic            we_q, we_d;
  logic [1:0]      k_q, k_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     ld_buf_q, ld_buf_d;
  logic [4:0]      wb_wa_q, wb_wa_d;
  logic            wb_we_q, wb_we_d;
  logic [XLEN-1:0] wb_res_q, wb_res_d;
  logic [31:0]     ext_val;

  mem_byte_ext u_ext (
    .bytes_i (ld_buf_q),
    .len_i   (len_q),
    .uns_i   (uns_q),
    .val_o   (ext_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      data_q   <= '0;
      len_q    <= '0;
      wr_q     <= 1'b0;
      uns_q    <= 1'b0;
      wa_q     <= '0;
      we_q     <= 1'b0;
      k_q      <= '0;
      cnt_q    <= '0;
      ld_buf_q <= '0;
      wb_wa_q  <= '0;
      wb_we_q  <= 1'b0;
      wb_res_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      len_q    <= len_d;
      wr_q     <= wr_d;
      uns_q    <= uns_d;
      wa_q     <= wa_d;
      we_q     <= we_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
      ld_buf_q <= ld_buf_d;
      wb_wa_q  <= wb_wa_d;
      wb_we_q  <= wb_we_d;
      wb_res_q <= wb_res_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    len_d    = len_q;
    wr_d     = wr_q;
    uns_d    = uns_q;
    wa_d     = wa_q;
    we_d     = we_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    ld_buf_d = ld_buf_q;
    wb_wa_d  = wb_wa_q;
    wb_we_d  = wb_we_q;
    wb_res_d = wb_res_q;
    stall_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ex_mem_e[E_EN]) begin
          stall_o  = 1'b1;
          addr_d   = res;
          data_d   = ex_mem_n;
          len_d    = ex_mem_e[E_LEN_HI:E_LEN_LO];
          wr_d     = ex_mem_e[E_WR];
          uns_d    = ex_mem_e[E_UNS];
          wa_d     = wa;
          we_d     = we;
          k_d      = '0;
          state_d  = StIssue;
          wb_wa_d  = '0;
          wb_we_d  = 1'b0;
          wb_res_d = '0;
        end else begin
          wb_wa_d  = wa;
          wb_we_d  = we;
          wb_res_d = res;
        end
      end
      StIssue: begin
        stall_o = 1'b1;
        if (mem_ack) begin
          if (wr_q) begin
            k_d = k_q + 2'd1;
            if (k_q == len_q) state_d = StDone;
          end else begin
            cnt_d   = CntW'(RD_LAT);
            state_d = StWait;
          end
        end
      end
      StWait: begin
        stall_o = 1'b1;
        if (cnt_q == CntW'(1)) begin
          ld_buf_d[{k_q, 3'b000} +: 8] = mem_din;
          k_d     = k_q + 2'd1;
          state_d = (k_q == len_q) ? StDone : StIssue;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        wb_wa_d = wa_q;
        if (wr_q) begin
          wb_we_d  = 1'b0;
          wb_res_d = addr_q;
        end else begin
          wb_we_d  = we_q;
          wb_res_d = XLEN'(ext_val);
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Port outputs are gated by state so they read zero outside an issuing beat.
  always_comb begin
    mem_req  = (state_q == StIssue);
    mem_wr   = mem_req & wr_q;
    mem_a    = mem_req ? addr_q + XLEN'(k_q) : '0;
    mem_dout = mem_req ? data_q[{k_q, 3'b000} +: 8] : 8'h00;
  end

  assign wa_o  = wb_wa_q;
  assign we_o  = wb_we_q;
  assign res_o = wb_res_q;

`ifdef MEM_FWD_EN
  assign fwd_we  = (state_q == StIssue || state_q == StWait) ? 1'b0 : wb_we_d;
  assign fwd_wa  = wb_wa_d;
  assign fwd_res = wb_res_d;
`endif

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: pass-through, stores, loads, backpressure, wrap and async reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ex_mem_e = '0;
  logic [31:0] ex_mem_n = '0;
  logic [31:0] res = '0;
  logic [4:0]  wa = '0;
  logic        we = 1'b0;
  logic        stall_o;
  logic [4:0]  wa_o;
  logic        we_o;
  logic [31:0] res_o;
  logic        mem_req;
  logic        mem_ack;
  logic        mem_wr;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
`ifdef MEM_FWD_EN
  logic        fwd_we;
  logic [4:0]  fwd_wa;
  logic [31:0] fwd_res;
`endif

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd_addr_q = '0;
  logic [31:0] blk_addr  = 32'hDEAD_0000;
  int          blk_cnt   = 0;
  logic [40:0] beat_log[$];

  mem_lsu #(.RD_LAT(1), .XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .ex_mem_e (ex_mem_e),
    .ex_mem_n (ex_mem_n),
    .res      (res),
    .wa       (wa),
    .we       (we),
    .stall_o  (stall_o),
    .wa_o     (wa_o),
    .we_o     (we_o),
    .res_o    (res_o),
    .mem_req  (mem_req),
    .mem_ack  (mem_ack),
    .mem_wr   (mem_wr),
    .mem_a    (mem_a),
    .mem_dout (mem_dout),
    .mem_din  (mem_din)
`ifdef MEM_FWD_EN
    ,
    .fwd_we   (fwd_we),
    .fwd_wa   (fwd_wa),
    .fwd_res  (fwd_res)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rd_byte(input logic [31:0] a);
    if (a == 32'h0000_1003) return 8'h80;
    return a[7:0] + 8'h11;
  endfunction

  // Memory model: one-cycle read data, beat log, optional ack hold-off on one address.
  assign mem_din = rd_byte(rd_addr_q);
  assign mem_ack = !(mem_req && mem_a == blk_addr && blk_cnt != 0);

  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      beat_log.push_back({mem_wr, mem_a, mem_dout});
      if (!mem_wr) rd_addr_q <= mem_a;
    end
    if (mem_req && mem_a == blk_addr && blk_cnt != 0) blk_cnt <= blk_cnt - 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && mem_req && !mem_ack) begin
      check("bp_addr", mem_a, blk_addr);
      check("bp_stall", {31'd0, stall_o}, 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [4:0] e, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] w, input logic wen, output int cyc);
    ex_mem_e = e;
    res      = a;
    ex_mem_n = d;
    wa       = w;
    we       = wen;
    beat_log.delete();
    #1;
    check("stall_comb", {31'd0, stall_o}, 32'd1);
    cyc = 0;
    do begin
      tick();
      cyc++;
    end while (stall_o && cyc < 200);
    if (cyc >= 200) check("op_timeout", 32'd0, 32'd1);
    ex_mem_e = '0;
    tick();
    cyc++;
  endtask

  int cyc;

  initial begin
    #2;
    check("rst_wa", {27'd0, wa_o}, 32'd0);
    check("rst_we", {31'd0, we_o}, 32'd0);
    check("rst_res", res_o, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Pass-through
    ex_mem_e = '0; wa = 5'd5; we = 1'b1; res = 32'h42;
    #1;
    check("pt_stall", {31'd0, stall_o}, 32'd0);
    tick();
    check("pt_wa", {27'd0, wa_o}, 32'd5);
    check("pt_we", {31'd0, we_o}, 32'd1);
    check("pt_res", res_o, 32'h42);
    check("pt_stall2", {31'd0, stall_o}, 32'd0);

    // SW: enable, len=3, write
    run_op(5'b11110, 32'h2000, 32'h1234_5678, 5'd7, 1'b1, cyc);
    check("sw_cyc", cyc, 32'd6);
    check("sw_nbeat", beat_log.size(), 32'd4);
    if (beat_log.size() == 4) begin
      check("sw_b0", {beat_log[0][40], beat_log[0][39:8], beat_log[0][7:0]} == {1'b1, 32'h2000, 8'h78}, 1);
      check("sw_b1", {beat_log[1][40], beat_log[1][39:8], beat_log[1][7:0]} == {1'b1, 32'h2001, 8'h56}, 1);
      check("sw_b2", {beat_log[2][40], beat_log[2][39:8], beat_log[2][7:0]} == {1'b1, 32'h2002, 8'h34}, 1);
      check("sw_b3", {beat_log[3][40], beat_log[3][39:8], beat_log[3][7:0]} == {1'b1, 32'h2003, 8'h12}, 1);
    end
    check("sw_we", {31'd0, we_o}, 32'd0);
    check("sw_res", res_o, 32'h2000);
    check("sw_wa", {27'd0, wa_o}, 32'd7);

    // LB / LBU at 0x1003 reading 0x80
    run_op(5'b10000, 32'h1003, 32'h0, 5'd9, 1'b1, cyc);
    check("lb_cyc", cyc, 32'd4);
    check("lb_res", res_o, 32'hFFFF_FF80);
    check("lb_we", {31'd0, we_o}, 32'd1);
    check("lb_wa", {27'd0, wa_o}, 32'd9);
    run_op(5'b10001, 32'h1003, 32'h0, 5'd10, 1'b1, cyc);
    check("lbu_res", res_o, 32'h0000_0080);
    check("lbu_wa", {27'd0, wa_o}, 32'd10);

    // LW with ack held low three cycles on beat 1
    blk_addr = 32'h1001;
    blk_cnt  = 3;
    run_op(5'b11100, 32'h1000, 32'h0, 5'd11, 1'b1, cyc);
    check("lwbp_cyc", cyc, 32'd13);
    check("lwbp_res", res_o, 32'h8013_1211);
    check("lwbp_blk", blk_cnt, 32'd0);
    blk_addr = 32'hDEAD_0000;

    // LW wrapping the address space
    run_op(5'b11100, 32'hFFFF_FFFE, 32'h0, 5'd12, 1'b1, cyc);
    check("wrap_cyc", cyc, 32'd10);
    check("wrap_nbeat", beat_log.size(), 32'd4);
    if (beat_log.size() == 4) begin
      check("wrap_a0", beat_log[0][39:8], 32'hFFFF_FFFE);
      check("wrap_a1", beat_log[1][39:8], 32'hFFFF_FFFF);
      check("wrap_a2", beat_log[2][39:8], 32'h0000_0000);
      check("wrap_a3", beat_log[3][39:8], 32'h0000_0001);
    end
    check("wrap_res", res_o, 32'h1211_100F);

    // Pass-through leaves nonzero WB values, then reset lands mid-LH in WAIT
    ex_mem_e = '0; wa = 5'd3; we = 1'b1; res = 32'h55;
    tick();
    ex_mem_e = 5'b10100; res = 32'h3000; wa = 5'd4;
    tick();
    check("lh_req_issue", {31'd0, mem_req}, 32'd1);
    tick();
    check("lh_in_wait", {31'd0, stall_o & ~mem_req}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("arst_wa", {27'd0, wa_o}, 32'd0);
    check("arst_we", {31'd0, we_o}, 32'd0);
    check("arst_res", res_o, 32'd0);
    check("arst_req", {31'd0, mem_req}, 32'd0);
    check("arst_a", mem_a, 32'd0);
    ex_mem_e = '0;
    #1;
    check("arst_stall", {31'd0, stall_o}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    run_op(5'b10001, 32'h1003, 32'h0, 5'd6, 1'b1, cyc);
    check("post_cyc", cyc, 32'd4);
    check("post_res", res_o, 32'h0000_0080);
    check("post_wa", {27'd0, wa_o}, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
